// File: rtl/tracer_pkg.sv
// Shared constants, mode/state enums and lane-geometry helpers for the
// tracer write (packing) and read (unpacking) paths.
package tracer_pkg;

  localparam int TRB_WIDTH       = 64;
  localparam int TRB_MAX_TRACES  = 32;
  localparam int TRB_NTRACE_BITS = 3;
  localparam int POS_W           = $clog2(TRB_WIDTH);
  localparam int LANE_LG_MAX     = $clog2(TRB_MAX_TRACES);

  typedef logic [TRB_NTRACE_BITS-1:0] ntrace_t;

  typedef enum logic [1:0] {
    TRACE_MODE     = 2'd0,
    W_STREAM_MODE  = 2'd1,
    R_STREAM_MODE  = 2'd2,
    RW_STREAM_MODE = 2'd3
  } trg_mode_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_REQ   = 2'd1,
    RD_DRAIN = 2'd2,
    RD_GAP   = 2'd3
  } rd_state_t;

  // log2 of the active lane count, clamped to the physical lanes.
  function automatic ntrace_t lane_log2(input ntrace_t n);
    if (int'(n) > LANE_LG_MAX) return ntrace_t'(LANE_LG_MAX);
    return n;
  endfunction

  function automatic logic [TRB_MAX_TRACES-1:0] lane_mask(input ntrace_t lg);
    return {TRB_MAX_TRACES{1'b1}} >> (TRB_MAX_TRACES - (1 << lg));
  endfunction

  // Index of the last sample in a word: TRB_WIDTH/L - 1.
  function automatic logic [POS_W-1:0] last_fill(input ntrace_t lg);
    return POS_W'((TRB_WIDTH >> lg) - 1);
  endfunction

endpackage

// File: rtl/tracer_stream_unpacker.sv
// Read path: requests a word from the logger, then serialises it L bits per
// cycle, LSB-first, with a one-cycle request gap between words.
module stream_unpacker
  import tracer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      active,
  input  ntrace_t                   lg,
  input  logic                      load_grant,
  input  logic [TRB_WIDTH-1:0]      data,
  output logic                      load_request,
  output logic [TRB_MAX_TRACES-1:0] stream,
  output logic                      stream_valid,
  output rd_state_t                 rd_state
);

  // Handshake: load_request is held high for the whole REQ state; the logger
  // answers with a single load_grant cycle carrying data. A grant seen in any
  // other state is ignored. stream is meaningful only while stream_valid=1.

  rd_state_t            state_q, state_d;
  logic [TRB_WIDTH-1:0] buf_q, buf_d;
  logic [POS_W-1:0]     cnt_q, cnt_d;

  assign rd_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RD_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    load_request = 1'b0;
    stream_valid = 1'b0;
    stream       = '0;
    case (state_q)
      RD_IDLE: begin
        if (active) state_d = RD_REQ;
      end
      RD_REQ: begin
        load_request = 1'b1;
        if (!active) begin
          state_d = RD_IDLE;
        end else if (load_grant) begin
          buf_d   = data;
          cnt_d   = '0;
          state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        stream_valid = 1'b1;
        stream       = buf_q[TRB_MAX_TRACES-1:0] & lane_mask(lg);
        buf_d        = buf_q >> (1 << lg);
        if (cnt_q == last_fill(lg)) begin
          cnt_d   = '0;
          state_d = RD_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!active) state_d = RD_IDLE;
      end
      RD_GAP: begin
        // One request-free cycle lets the logger drop its finished_read.
        state_d = active ? RD_REQ : RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
    if (flush) begin
      state_d = RD_IDLE;
      buf_d   = '0;
      cnt_d   = '0;
    end
  end

endmodule

// File: rtl/tracer.sv
// Tracer stage of the streaming trace buffer: packs samples into words for
// the logger, records the trigger position, and streams words back out.
module tracer
  import tracer_pkg::*;
(
  input  logic                       CLK_I,
  input  logic                       RST_I,
  input  logic [1:0]                 MODE_I,
  input  logic [TRB_NTRACE_BITS-1:0] NTRACE_I,
  input  logic [TRB_MAX_TRACES-1:0]  TRACE_I,
  input  logic                       TRACE_VALID_I,
  input  logic                       TRIGGER_I,
  output logic                       TRG_EVENT_O,
  output logic [POS_W-1:0]           EVENT_POS_O,
  input  logic                       TRG_DELAYED_I,
  output logic [TRB_WIDTH-1:0]       DATA_O,
  output logic                       STORE_O,
  input  logic                       STORE_PERM_I,
  output logic                       OVERFLOW_O,
  output logic                       LOAD_REQUEST_O,
  input  logic                       LOAD_GRANT_I,
  input  logic [TRB_WIDTH-1:0]       DATA_I,
  output logic [TRB_MAX_TRACES-1:0]  STREAM_O,
  output logic                       STREAM_VALID_O
);

  trg_mode_t            mode_q;
  ntrace_t              ntrace_q;
  logic [POS_W-1:0]     fill_q;
  logic [TRB_WIDTH-1:0] pack_q;
  logic [TRB_WIDTH-1:0] data_q;
  logic                 store_q;
  logic                 overflow_q;
  logic                 trg_event_q;
  logic [POS_W-1:0]     event_pos_q;

  logic                 flush;
  ntrace_t              lg;
  logic [POS_W-1:0]     offset;
  logic [TRB_WIDTH-1:0] word_next;
  logic                 wr_active;
  logic                 rd_active;
  rd_state_t            rd_state;

  // Any change of mode or lane count invalidates both in-flight paths.
  assign flush     = (MODE_I != mode_q) || (NTRACE_I != ntrace_q);
  assign lg        = lane_log2(ntrace_q);
  assign offset    = fill_q << lg;
  assign word_next = pack_q | (TRB_WIDTH'(TRACE_I & lane_mask(lg)) << offset);
  assign wr_active = !flush && ((mode_q == W_STREAM_MODE) || (mode_q == RW_STREAM_MODE) ||
                                ((mode_q == TRACE_MODE) && !TRG_DELAYED_I));
  assign rd_active = !flush && ((mode_q == R_STREAM_MODE) || (mode_q == RW_STREAM_MODE));

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      mode_q      <= TRACE_MODE;
      ntrace_q    <= '0;
      fill_q      <= '0;
      pack_q      <= '0;
      data_q      <= '0;
      store_q     <= 1'b0;
      overflow_q  <= 1'b0;
      trg_event_q <= 1'b0;
      event_pos_q <= '0;
    end else begin
      mode_q   <= trg_mode_t'(MODE_I);
      ntrace_q <= NTRACE_I;
      store_q  <= 1'b0;
      if (wr_active) begin
        if (TRACE_VALID_I) begin
          if (fill_q == last_fill(lg)) begin
            fill_q <= '0;
            pack_q <= '0;
            if (STORE_PERM_I) begin
              data_q  <= word_next;
              store_q <= 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end else begin
            fill_q <= fill_q + 1'b1;
            pack_q <= word_next;
          end
        end
      end else begin
        // Flushed, stopped by the delayed trigger, or read-only mode.
        fill_q <= '0;
        pack_q <= '0;
      end
      if (!flush && (mode_q == TRACE_MODE) && TRIGGER_I && !trg_event_q) begin
        trg_event_q <= 1'b1;
        event_pos_q <= offset;
      end
    end
  end

  assign DATA_O      = data_q;
  assign STORE_O     = store_q;
  assign OVERFLOW_O  = overflow_q;
  assign TRG_EVENT_O = trg_event_q;
  assign EVENT_POS_O = event_pos_q;

  stream_unpacker u_unpacker (
    .clk          (CLK_I),
    .rst          (RST_I),
    .flush        (flush),
    .active       (rd_active),
    .lg           (lg),
    .load_grant   (LOAD_GRANT_I),
    .data         (DATA_I),
    .load_request (LOAD_REQUEST_O),
    .stream       (STREAM_O),
    .stream_valid (STREAM_VALID_O),
    .rd_state     (rd_state)
  );

endmodule

// File: tb/tb_tracer.sv
// Directed bench for tracer: a vector table for packing/trigger plus
// hand-written sequences for overflow, delayed trigger, streaming and flush.
module tb_tracer;
  import tracer_pkg::*;

  logic                       clk;
  logic                       rst;
  logic [1:0]                 mode;
  logic [TRB_NTRACE_BITS-1:0] ntrace;
  logic [TRB_MAX_TRACES-1:0]  trace;
  logic                       trace_valid;
  logic                       trigger;
  logic                       trg_event;
  logic [POS_W-1:0]           event_pos;
  logic                       trg_delayed;
  logic [TRB_WIDTH-1:0]       data_o;
  logic                       store;
  logic                       store_perm;
  logic                       overflow;
  logic                       load_request;
  logic                       load_grant;
  logic [TRB_WIDTH-1:0]       data_i;
  logic [TRB_MAX_TRACES-1:0]  stream;
  logic                       stream_valid;

  int total = 0;
  int bad = 0;
  int store_cnt = 0;
  logic [TRB_WIDTH-1:0] exp_q[$];

  tracer dut (
    .CLK_I          (clk),
    .RST_I          (rst),
    .MODE_I         (mode),
    .NTRACE_I       (ntrace),
    .TRACE_I        (trace),
    .TRACE_VALID_I  (trace_valid),
    .TRIGGER_I      (trigger),
    .TRG_EVENT_O    (trg_event),
    .EVENT_POS_O    (event_pos),
    .TRG_DELAYED_I  (trg_delayed),
    .DATA_O         (data_o),
    .STORE_O        (store),
    .STORE_PERM_I   (store_perm),
    .OVERFLOW_O     (overflow),
    .LOAD_REQUEST_O (load_request),
    .LOAD_GRANT_I   (load_grant),
    .DATA_I         (data_i),
    .STREAM_O       (stream),
    .STREAM_VALID_O (stream_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trace       = '0;
    trace_valid = 1'b0;
    trigger     = 1'b0;
    trg_delayed = 1'b0;
    store_perm  = 1'b1;
    load_grant  = 1'b0;
    data_i      = '0;
  endtask

  task automatic sample(input logic [31:0] v, input logic perm);
    trace       = v;
    trace_valid = 1'b1;
    store_perm  = perm;
    step();
    trace_valid = 1'b0;
    store_perm  = 1'b1;
  endtask

  // scoreboard: every store must match the next expected word
  always @(negedge clk) begin
    if (!rst && store) begin
      store_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_store: got %h expected no store", data_o);
      end else begin
        logic [TRB_WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          bad++;
          $display("FAIL store_data: got %h expected %h", data_o, e);
        end
      end
    end
  end

  typedef struct {
    logic [31:0] trace;
    logic        valid;
    logic        trig;
    logic        exp_store;
    logic        exp_trg;
    logic [5:0]  exp_pos;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int sc;

    // table: two words in trace_mode n=3, trigger on 3rd sample of word 2
    for (int i = 0; i < 18; i++) begin
      tbl[i].trace     = '0;
      tbl[i].valid     = 1'b0;
      tbl[i].trig      = 1'b0;
      tbl[i].exp_store = 1'b0;
      tbl[i].exp_trg   = 1'b0;
      tbl[i].exp_pos   = 6'd0;
    end
    for (int i = 0; i < 8; i++) begin
      tbl[i].trace     = 32'(i + 1);
      tbl[i].valid     = 1'b1;
      tbl[i + 9].trace = 32'(8'h11 + i);
      tbl[i + 9].valid = 1'b1;
    end
    tbl[7].exp_store  = 1'b1;
    tbl[16].exp_store = 1'b1;
    tbl[11].trig      = 1'b1;
    tbl[14].trig      = 1'b1;
    for (int i = 11; i < 18; i++) begin
      tbl[i].exp_trg = 1'b1;
      tbl[i].exp_pos = 6'd16;
    end

    idle_inputs();
    rst    = 1'b1;
    mode   = TRACE_MODE;
    ntrace = 3'd0;
    step();
    step();
    chk("rst_store", 64'(store), 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_trg", 64'(trg_event), 64'd0);
    chk("rst_pos", 64'(event_pos), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_req", 64'(load_request), 64'd0);
    chk("rst_svalid", 64'(stream_valid), 64'd0);
    chk("rst_stream", 64'(stream), 64'd0);
    rst = 1'b0;

    ntrace = 3'd3;
    step();
    exp_q.push_back(64'h0807060504030201);
    exp_q.push_back(64'h1817161514131211);
    for (int i = 0; i < 18; i++) begin
      trace       = tbl[i].trace;
      trace_valid = tbl[i].valid;
      trigger     = tbl[i].trig;
      step();
      chk($sformatf("tbl%0d_store", i), 64'(store), 64'(tbl[i].exp_store));
      chk($sformatf("tbl%0d_trg", i), 64'(trg_event), 64'(tbl[i].exp_trg));
      chk($sformatf("tbl%0d_pos", i), 64'(event_pos), 64'(tbl[i].exp_pos));
      chk($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'd0);
    end
    idle_inputs();
    chk("data_hold", data_o, 64'h1817161514131211);

    // overflow with L=32: second sample dropped, next word stores
    ntrace = 3'd5;
    step();
    sample(32'hAAAAAAAA, 1'b1);
    sample(32'h55555555, 1'b0);
    chk("ovf_nostore", 64'(store), 64'd0);
    chk("ovf_set", 64'(overflow), 64'd1);
    exp_q.push_back(64'h2222222211111111);
    sample(32'h11111111, 1'b1);
    sample(32'h22222222, 1'b1);
    chk("ovf_next_store", 64'(store), 64'd1);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    step();

    // delayed trigger after 5 samples: capture stops, partial word discarded
    ntrace = 3'd3;
    step();
    sc = store_cnt;
    for (int i = 0; i < 5; i++) sample(32'(8'h31 + i), 1'b1);
    trg_delayed = 1'b1;
    for (int i = 0; i < 5; i++) sample(32'(8'h36 + i), 1'b1);
    step();
    chk("delayed_nostore", 64'(store_cnt - sc), 64'd0);
    trg_delayed = 1'b0;
    step();
    exp_q.push_back(64'h2827262524232221);
    for (int i = 0; i < 8; i++) sample(32'(8'h21 + i), 1'b1);
    step();
    chk("after_delayed_store", 64'(store_cnt - sc), 64'd1);

    // read path, r_stream_mode n=3
    mode = R_STREAM_MODE;
    step();
    chk("rd_idle_req", 64'(load_request), 64'd0);
    step();
    chk("rd_req", 64'(load_request), 64'd1);
    load_grant = 1'b1;
    data_i     = 64'h0807060504030201;
    for (int i = 0; i < 8; i++) begin
      step();
      load_grant = 1'b0;
      data_i     = '0;
      chk($sformatf("rd_stream%0d", i), 64'(stream), 64'(i + 1));
      chk($sformatf("rd_valid%0d", i), 64'(stream_valid), 64'd1);
      chk($sformatf("rd_drain_req%0d", i), 64'(load_request), 64'd0);
    end
    load_grant = 1'b1;
    data_i     = 64'hDEADBEEFDEADBEEF;
    step();
    chk("rd_gap_req", 64'(load_request), 64'd0);
    chk("rd_gap_valid", 64'(stream_valid), 64'd0);
    step();
    load_grant = 1'b0;
    chk("rd_req_again", 64'(load_request), 64'd1);
    chk("rd_stray_grant", 64'(stream_valid), 64'd0);

    // mode change mid-drain
    load_grant = 1'b1;
    data_i     = 64'h0807060504030201;
    step();
    load_grant = 1'b0;
    step();
    step();
    chk("fl_pre_stream", 64'(stream), 64'd3);
    mode = RW_STREAM_MODE;
    step();
    chk("fl_valid", 64'(stream_valid), 64'd0);
    chk("fl_req", 64'(load_request), 64'd0);
    chk("fl_stream", 64'(stream), 64'd0);
    step();
    chk("fl_req_resume", 64'(load_request), 64'd1);
    load_grant = 1'b1;
    data_i     = 64'h00000000000000C5;
    step();
    load_grant = 1'b0;
    chk("fl_new_word", 64'(stream), 64'hC5);

    // reset mid-REQ
    for (int i = 0; i < 9; i++) step();
    chk("pre_rst_req", 64'(load_request), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_req", 64'(load_request), 64'd0);
    chk("mid_rst_valid", 64'(stream_valid), 64'd0);
    chk("mid_rst_trg", 64'(trg_event), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    chk("mid_rst_data", data_o, 64'd0);
    step();

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
